lector_memoria: RTL and testbench
=================================

// Module: lector_memoria
// PURPOSE
//  Burst read port for the 16-entry register file.
//  - Accepts a start request with a start select code and a word count.
//  - Streams the selected registers out one word per accepted beat, with a valid/ready handshake.
//  - Sits between the register file's parallel outputs and any sequential consumer (ALU sequencer, debug dump, serializer).
//  - Select codes match the register file write side: code k <-> register k+1.
// PARAMETERS
//  N     16   word width of each register and of dout
// PORTS
//  clk         in   1      rising-edge clock; single clock domain
//  rst         in   1      reset, synchronous, active-low (0 = reset on next rising clk)
//  regs        in   16*N   register file outputs; regs[k*N +: N] = register with select code k
//  start       in   1      burst request; sampled only in IDLE
//  addr        in   4      select code of first word
//  len         in   4      word count minus 1 (0 -> 1 word, 15 -> 16 words)
//  dout        out  N      current word
//  dout_valid  out  1      dout holds a word not yet accepted
//  dout_ready  in   1      consumer accepts dout this cycle
//  last        out  1      qualifies dout: final word of the burst
//  busy        out  1      burst in progress (SEND or DONE)
//  done        out  1      one-cycle pulse after the final word is accepted
//  chk         out  N      burst checksum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge):
//    - State goes to IDLE.
//    - dout, dout_valid, last, busy, done, chk and internal pointer/count are all cleared to 0.
//    - Reset overrides everything. A burst aborted by reset emits no done.
//  - FSM states: IDLE, SEND, DONE.
//  - IDLE:
//    - start==1 is accepted at a clk edge.
//    - On accept: ptr<=addr, rem<=len, dout<=regs[addr], dout_valid<=1, last<=(len==0), busy<=1.
//    - Go to SEND. Latency is one cycle from start to the first valid word.
//  - SEND:
//    - A beat is accepted when dout_valid && dout_ready.
//    - No beat (valid && !ready): dout, last and ptr hold stable. Writes to the register file are not reflected until the next load.
//    - Beat with rem!=0: ptr<=ptr+1 mod 16 (15 wraps to 0), rem<=rem-1, dout<=regs[ptr+1], last<=(rem==1).
//      Back-to-back beats give full throughput, one word per cycle.
//    - Beat with rem==0: dout_valid<=0, last<=0, done<=1, go to DONE.
//  - DONE:
//    - Lasts one cycle; busy stays 1 here.
//    - Next edge: done<=0, busy<=0, go to IDLE.
//    - A new start is accepted no earlier than the cycle busy reads 0.
//  - start outside IDLE is ignored. addr and len are only sampled at accept.
//  - Each word is sampled from regs when loaded into dout:
//    - the first word at accept;
//    - each later word at the previous beat.
//    - A register write during a burst is seen only by words loaded after that write.
//  - last is 0 whenever dout_valid is 0. dout keeps its last value when not valid.
// CONFIGURATION
//  LECTOR_CHECKSUM_EN
//  - Defined:
//    - chk is cleared at start accept.
//    - On every accepted beat, chk <= chk + dout (mod 2^N).
//    - The final sum is valid from the done pulse until the next accept.
//  - Undefined: chk is tied to 0 and there is no adder logic. The port is always present.
// TESTING
//  Bench drives regs with the register file reset image:
//  c0=0003 c1=0003 c2=0001 c3=0001 c4..c8=0000 c9=0404 c10..c12=0004 c13=8004 c14=A204 c15=8004.
//  1. Reset:
//     - rst=0 for 2 clk with start=1 -> all outputs 0, busy stays 0.
//     - After rst=1, busy rises only after a start.
//  2. Basic burst:
//     - addr=0, len=3, dout_ready=1 -> dout 0003,0003,0001,0001 on 4 consecutive cycles starting 1 cycle after start.
//     - last only on the 4th word; done one cycle later; busy low the cycle after that.
//  3. Wrap:
//     - addr=14, len=2 -> A204, 8004, 0003, with last on 0003.
//     - Single word: addr=9, len=0 -> 0404 with last=1 on the first beat.
//  4. Backpressure:
//     - addr=13, len=1, dout_ready=0 for 3 cycles -> dout=8004 with valid held stable.
//     - Raise ready -> 8004 then A204; exactly 2 beats.
//  5. Ignored start and mid-burst reset:
//     - start pulsed with addr=0 during a burst from addr=9 -> stream unchanged (0404, 0004, ...).
//     - rst=0 during the second beat -> outputs 0 next cycle, no done pulse.
//  6. Checksum (LECTOR_CHECKSUM_EN defined):
//     - addr=13, len=2 -> chk=A20C at done.
//     - Build without the macro -> chk stays 0.

Source files
------------

// File: rtl/lector_memoria.sv
// Burst reader for the 16-entry register file; optional checksum under LECTOR_CHECKSUM_EN.
// Latency: first word is valid one cycle after start is accepted, then one word per cycle.
// Backpressure: when dout_ready is low, dout, last and the pointer hold until the word is accepted.
module lector_memoria #(
    parameter int N = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [16*N-1:0] regs,
    input  logic            start,
    input  logic [3:0]      addr,
    input  logic [3:0]      len,
    output logic [N-1:0]    dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            last,
    output logic            busy,
    output logic            done,
    output logic [N-1:0]    chk
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   state;
    logic [3:0]   ptr;
    logic [3:0]   rem;
    logic [3:0]   ptr_nxt;
    logic         accept;
    logic         beat;
    logic [N-1:0] word [16];

    genvar k;
    generate
        for (k = 0; k < 16; k++) begin : g_word
            assign word[k] = regs[k*N +: N];
        end
    endgenerate

    assign ptr_nxt = ptr + 4'd1;
    assign accept  = (state == IDLE) && start;
    assign beat    = (state == SEND) && dout_valid && dout_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            rem        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            last       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ptr        <= addr;
                        rem        <= len;
                        dout       <= word[addr];
                        dout_valid <= 1'b1;
                        last       <= (len == 4'd0);
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (beat) begin
                        if (rem != 4'd0) begin
                            // Next word is sampled now, so later register writes are not seen by it.
                            ptr  <= ptr_nxt;
                            rem  <= rem - 4'd1;
                            dout <= word[ptr_nxt];
                            last <= (rem == 4'd1);
                        end else begin
                            dout_valid <= 1'b0;
                            last       <= 1'b0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LECTOR_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            chk <= '0;
        end else if (accept) begin
            chk <= '0;
        end else if (beat) begin
            chk <= chk + dout;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = accept ^ beat;
    assign chk       = '0;
`endif

endmodule

// File: tb/tb_lector_memoria.sv
// Bench for lector_memoria: directed spec scenarios plus randomized bursts checked against a queue-free word model.
module tb_lector_memoria;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] regs_bus;
    logic         start;
    logic [3:0]   addr;
    logic [3:0]   len;
    logic [15:0]  dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         last;
    logic         busy;
    logic         done;
    logic [15:0]  chk;

    logic [15:0] img [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        regs_bus = '0;
        for (int k = 0; k < 16; k++) regs_bus[k*16 +: 16] = img[k];
    end

    lector_memoria #(.N(16)) dut (
        .clk(clk), .rst(rst), .regs(regs_bus), .start(start), .addr(addr), .len(len),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .last(last),
        .busy(busy), .done(done), .chk(chk)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_reset_image();
        img[0] = 16'h0003; img[1] = 16'h0003; img[2] = 16'h0001; img[3] = 16'h0001;
        for (int k = 4; k <= 8; k++) img[k] = 16'h0000;
        img[9] = 16'h0404; img[10] = 16'h0004; img[11] = 16'h0004; img[12] = 16'h0004;
        img[13] = 16'h8004; img[14] = 16'hA204; img[15] = 16'h8004;
    endtask

    function automatic logic [15:0] exp_chk(input logic [15:0] sum);
`ifdef LECTOR_CHECKSUM_EN
        return sum;
`else
        return 16'h0000;
`endif
    endfunction

    // One burst from addr a with len l; the model tracks the word the DUT should be holding.
    task automatic burst(input logic [3:0] a, input logic [3:0] l, input int stall_pct,
                         input int init_stall, input bit poke, input bit wr);
        logic [15:0] cur;
        logic [15:0] sum;
        logic [3:0]  nxt;
        int idx;
        int cyc;
        bit rdy;
        start = 1'b1; addr = a; len = l; dout_ready = 1'b0;
        cur = img[a];
        sum = '0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; addr = 4'($urandom); len = 4'($urandom);
        idx = 0;
        cyc = 0;
        while (idx <= int'(l) && cyc < 200) begin
            check("valid", dout_valid, 1);
            check("dout", dout, cur);
            check("last", last, idx == int'(l));
            check("busy", busy, 1);
            check("done_mid", done, 0);
            if (wr && cyc == 1) begin
                img[a] = ~img[a];
                img[4'(a + 4'd1)] = 16'($urandom);
            end
            if (poke && cyc == 1) begin
                start = 1'b1; addr = 4'd0; len = 4'd0;
            end
            rdy = (cyc >= init_stall) && ($urandom_range(0, 99) >= stall_pct);
            dout_ready = rdy;
            if (rdy) begin
                sum = sum + cur;
                nxt = 4'(int'(a) + idx + 1);
                if (idx < int'(l)) cur = img[nxt];
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (rdy) idx++;
            cyc++;
        end
        check("timeout", cyc < 200, 1);
        if (stall_pct == 0) check("cycles", cyc, int'(l) + 1 + init_stall);
        dout_ready = 1'($urandom);
        check("valid_end", dout_valid, 0);
        check("last_end", last, 0);
        check("done_pulse", done, 1);
        check("busy_done", busy, 1);
        check("chk_done", chk, exp_chk(sum));
        @(posedge clk);
        @(negedge clk);
        check("done_clear", done, 0);
        check("busy_clear", busy, 0);
        check("chk_hold", chk, exp_chk(sum));
    endtask

    initial begin
        load_reset_image();
        rst = 1'b0; start = 1'b1; addr = 4'd0; len = 4'd3; dout_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_chk", chk, 0);
        rst = 1'b1; start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_valid", dout_valid, 0);
        end

        burst(4'd0, 4'd3, 0, 0, 1'b0, 1'b0);
        burst(4'd14, 4'd2, 0, 0, 1'b0, 1'b0);
        burst(4'd9, 4'd0, 0, 0, 1'b0, 1'b0);
        burst(4'd13, 4'd1, 0, 3, 1'b0, 1'b0);
        burst(4'd9, 4'd3, 0, 0, 1'b1, 1'b0);
        burst(4'd13, 4'd2, 0, 0, 1'b0, 1'b0);
        burst(4'd15, 4'd15, 0, 0, 1'b0, 1'b0);

        // Mid-burst reset: no done pulse may follow.
        start = 1'b1; addr = 4'd9; len = 4'd3; dout_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("mr_word0", dout, 16'h0404);
        @(negedge clk);
        check("mr_word1", dout, 16'h0004);
        rst = 1'b0;
        @(negedge clk);
        check("mr_dout", dout, 0);
        check("mr_valid", dout_valid, 0);
        check("mr_last", last, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_chk", chk, 0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("mr_no_done", done, 0);
            check("mr_idle", busy, 0);
        end

        // Register writes during a stalled first word.
        burst(4'd2, 4'd3, 0, 3, 1'b0, 1'b1);

        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 16; k++) img[k] = 16'($urandom);
            burst(4'($urandom), 4'($urandom), 35, int'($urandom_range(0, 2)),
                  1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
